kv_mem_block: RTL and testbench

Key/value storage array that answers the controller's per-operation sub-FSMs (GET/SET/DEL): it performs combinational key lookup, indexed read, write/insert and delete on a bank of NUM_ENTRIES register cells. It sits directly below the controller and drives the hit/index feedback that the sub-FSMs consume in the same cycle. It also tracks occupancy and free slots, and runs a multi-cycle flush sweep.

---
 rtl/ctrl_types_pkg.sv | 25 ++
 rtl/kv_prio_onehot.sv | 17 +
 rtl/kv_mem_block.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_kv_mem_block.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_types_pkg.sv
// ctrl_types_pkg
//   Types shared between the key/value storage block and the controller
//   sub-FSMs (GET/SET/DEL) that drive it.
//   - kv_mem_state_e : storage block FSM states (idle / flush sweep)
//   - kv_mem_cmd_t   : per-cycle command bundle as the controller sees it
//                      (select, write, delete, one-hot target index)
package ctrl_types_pkg;

  // Cell count the controller is built against; the storage block itself is
  // parameterised and only the command bundle is tied to this width.
  localparam int KV_CMD_IDX_W = 16;

  typedef enum logic [0:0] {
    KV_IDLE  = 1'b0,
    KV_FLUSH = 1'b1
  } kv_mem_state_e;

  typedef struct packed {
    logic                    sel;   // 0 = key access, 1 = indexed access
    logic                    wr;    // write command
    logic                    del;   // delete command (targets idx)
    logic [KV_CMD_IDX_W-1:0] idx;   // one-hot target cell
  } kv_mem_cmd_t;

endpackage

// File: rtl/kv_prio_onehot.sv
// kv_prio_onehot
//   Lowest-set-bit selector: returns a one-hot vector with only the lowest
//   set bit of req_in kept, or zero when req_in is zero.
//   Ports:
//     req_in  [WIDTH-1:0]  request vector
//     gnt_out [WIDTH-1:0]  one-hot lowest request (0 if none)
module kv_prio_onehot #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] req_in,
  output logic [WIDTH-1:0] gnt_out
);

  // x & -x isolates the lowest set bit.
  assign gnt_out = req_in & (~req_in + WIDTH'(1));

endmodule

// File: rtl/kv_mem_block.sv
// kv_mem_block
//   Key/value storage array beneath the controller. NUM_ENTRIES cells, each
//   holding a valid bit, a key and a value. Provides combinational key
//   lookup / indexed read, and commits keyed or indexed writes and deletes
//   on the rising edge of the command cycle. Tracks occupancy and the lowest
//   free cell, and runs a NUM_ENTRIES-cycle flush sweep.
//
//   Interface protocol: there is no valid/ready handshake. A command is
//   whatever write_in/delete_in/flush_in show in a cycle; hit, hit_idx,
//   value_out, free_valid and free_idx answer the current key_in/idx_in
//   within the same cycle, and state changes are visible from the next one.
//
//   Ports:
//     clk, rst_n   clock; asynchronous active-low reset
//     key_in       key for lookup / keyed write
//     value_in     data for write
//     select_in    0 = key-based access, 1 = indexed access via idx_in
//     write_in     write command
//     delete_in    delete command, targets idx_in
//     idx_in       one-hot target cell
//     flush_in     single-cycle pulse starting the flush sweep
//     hit          accessed cell is valid
//     hit_idx      one-hot index of the hit cell, 0 if no hit
//     value_out    value of the hit cell, 0 if no hit
//     free_valid   at least one cell is empty
//     free_idx     one-hot lowest empty cell, 0 if full
//     count        number of valid cells
//     busy         flush sweep in progress
//     err          sticky illegal-command flag (only with KV_MEM_ERR_EN)
//     dbg_state    current FSM state
//
//   Build option: define KV_MEM_ERR_EN to add the sticky err output.
//   Without it illegal commands are still dropped in the same way.
module kv_mem_block
  import ctrl_types_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int KEY_WIDTH   = 32,
  parameter int VALUE_WIDTH = 64
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [KEY_WIDTH-1:0]               key_in,
  input  logic [VALUE_WIDTH-1:0]             value_in,
  input  logic                               select_in,
  input  logic                               write_in,
  input  logic                               delete_in,
  input  logic [NUM_ENTRIES-1:0]             idx_in,
  input  logic                               flush_in,
  output logic                               hit,
  output logic [NUM_ENTRIES-1:0]             hit_idx,
  output logic [VALUE_WIDTH-1:0]             value_out,
  output logic                               free_valid,
  output logic [NUM_ENTRIES-1:0]             free_idx,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   count,
  output logic                               busy,
`ifdef KV_MEM_ERR_EN
  output logic                               err,
`endif
  output kv_mem_state_e                      dbg_state
);

  localparam int CW = $clog2(NUM_ENTRIES + 1);
  localparam int PW = $clog2(NUM_ENTRIES);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  kv_mem_state_e          state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [KEY_WIDTH-1:0]   key_q [NUM_ENTRIES];
  logic [KEY_WIDTH-1:0]   key_d [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0] val_q [NUM_ENTRIES];
  logic [VALUE_WIDTH-1:0] val_d [NUM_ENTRIES];
  logic [CW-1:0]          count_q, count_d;

  // ---------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------
  logic [NUM_ENTRIES-1:0] match;
  logic [NUM_ENTRIES-1:0] key_hit_idx;
  logic [NUM_ENTRIES-1:0] free_vec;
  logic [NUM_ENTRIES-1:0] idx_valid;
  logic [NUM_ENTRIES-1:0] acc_idx;
  logic                   key_hit;
  logic                   idx_ok;
  logic                   in_flush;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match[i] = valid_q[i] && (key_q[i] == key_in);
    end
  end

  // Keys are unique in normal use; the lowest match wins if they are not.
  kv_prio_onehot #(.WIDTH(NUM_ENTRIES)) u_hit_sel (
    .req_in  (match),
    .gnt_out (key_hit_idx)
  );

  kv_prio_onehot #(.WIDTH(NUM_ENTRIES)) u_free_sel (
    .req_in  (~valid_q),
    .gnt_out (free_vec)
  );

  assign key_hit   = |key_hit_idx;
  assign idx_ok    = $onehot(idx_in);
  assign idx_valid = idx_in & valid_q;
  assign in_flush  = (state_q == KV_FLUSH);

  // A malformed index never reports a hit, so value_out cannot OR together
  // several cells.
  always_comb begin
    acc_idx = '0;
    if (!in_flush) begin
      if (select_in) begin
        acc_idx = idx_ok ? idx_valid : '0;
      end else begin
        acc_idx = key_hit_idx;
      end
    end
  end

  always_comb begin
    value_out = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (acc_idx[i]) begin
        value_out = value_out | val_q[i];
      end
    end
  end

  assign hit        = |acc_idx;
  assign hit_idx    = acc_idx;
  assign free_idx   = free_vec;
  assign free_valid = |free_vec;
  assign count      = count_q;

  // ---------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------
  logic                   flush_start;
  logic                   idle_cmd;
  logic                   do_del;
  logic                   wr_req;
  logic                   do_idx_wr;
  logic                   do_key_upd;
  logic                   do_key_ins;
  logic [NUM_ENTRIES-1:0] wr_vec;
  logic [NUM_ENTRIES-1:0] clr_vec;
  logic                   cnt_inc;
  logic                   cnt_dec;

  // A flush request in IDLE swallows any same-cycle write/delete.
  assign flush_start = (state_q == KV_IDLE) && flush_in;
  assign idle_cmd    = (state_q == KV_IDLE) && !flush_in;

  // Delete takes priority; a write in the same cycle is dropped.
  assign do_del     = idle_cmd && delete_in && idx_ok;
  assign wr_req     = idle_cmd && write_in && !delete_in;
  assign do_idx_wr  = wr_req && select_in && idx_ok;
  assign do_key_upd = wr_req && !select_in && key_hit;
  assign do_key_ins = wr_req && !select_in && !key_hit && (|free_vec);

  // An overwrite rewrites the key with key_in, which equals the stored key.
  always_comb begin
    wr_vec = '0;
    if (do_idx_wr) begin
      wr_vec = idx_in;
    end else if (do_key_upd) begin
      wr_vec = key_hit_idx;
    end else if (do_key_ins) begin
      wr_vec = free_vec;
    end
  end

  always_comb begin
    clr_vec = '0;
    if (do_del) begin
      clr_vec = idx_in;
    end
    if (in_flush) begin
      clr_vec = NUM_ENTRIES'(1) << ptr_q;
    end
  end

  assign cnt_inc = (do_idx_wr && !(|idx_valid)) || do_key_ins;
  assign cnt_dec = (do_del && (|idx_valid)) || (in_flush && valid_q[ptr_q]);

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    val_d   = val_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (clr_vec[i]) begin
        valid_d[i] = 1'b0;
        key_d[i]   = '0;
        val_d[i]   = '0;
      end else if (wr_vec[i]) begin
        valid_d[i] = 1'b1;
        key_d[i]   = key_in;
        val_d[i]   = value_in;
      end
    end
  end

  assign count_d = count_q + CW'(cnt_inc) - CW'(cnt_dec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        key_q[i] <= '0;
        val_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        key_q[i] <= key_d[i];
        val_q[i] <= val_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= KV_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      KV_IDLE: begin
        if (flush_in) begin
          state_d = KV_FLUSH;
          ptr_d   = '0;
        end
      end
      KV_FLUSH: begin
        if (ptr_q == PW'(NUM_ENTRIES - 1)) begin
          state_d = KV_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PW'(1);
        end
      end
      default: begin
        state_d = KV_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q == KV_FLUSH);
    dbg_state = state_q;
  end

  // ---------------------------------------------------------------------
  // Sticky illegal-command flag
  // ---------------------------------------------------------------------
`ifdef KV_MEM_ERR_EN
  logic illegal;
  logic err_q, err_d;

  always_comb begin
    illegal = idle_cmd && (
                (delete_in && !idx_ok) ||
                (delete_in && write_in) ||
                (wr_req && select_in && !idx_ok) ||
                (wr_req && !select_in && !key_hit && !(|free_vec)));
  end

  always_comb begin
    err_d = err_q;
    if (flush_start) begin
      err_d = 1'b0;
    end else if (illegal) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_kv_mem_block.sv
// tb_kv_mem_block
//   Directed bench for kv_mem_block. The driver sets inputs just after each
//   falling edge and, when a cycle is to be checked, pushes the expected
//   output bundle onto exp_q and raises probe. A separate monitor samples
//   the outputs 2 time units later (well before the next rising edge),
//   pops the expectation and compares.
module tb_kv_mem_block;

  localparam int N  = 16;
  localparam int KW = 32;
  localparam int VW = 64;
  localparam int CW = $clog2(N + 1);
  localparam int EW = 1 + N + VW + 1 + N + CW + 1 + 1;

`ifdef KV_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  import ctrl_types_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [KW-1:0] key_in    = '0;
  logic [VW-1:0] value_in  = '0;
  logic          select_in = 1'b0;
  logic          write_in  = 1'b0;
  logic          delete_in = 1'b0;
  logic [N-1:0]  idx_in    = '0;
  logic          flush_in  = 1'b0;

  logic          hit;
  logic [N-1:0]  hit_idx;
  logic [VW-1:0] value_out;
  logic          free_valid;
  logic [N-1:0]  free_idx;
  logic [CW-1:0] count;
  logic          busy;
  logic          err_obs;
  kv_mem_state_e dbg_state;

  kv_mem_block #(
    .NUM_ENTRIES (N),
    .KEY_WIDTH   (KW),
    .VALUE_WIDTH (VW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .value_in   (value_in),
    .select_in  (select_in),
    .write_in   (write_in),
    .delete_in  (delete_in),
    .idx_in     (idx_in),
    .flush_in   (flush_in),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .value_out  (value_out),
    .free_valid (free_valid),
    .free_idx   (free_idx),
    .count      (count),
    .busy       (busy),
`ifdef KV_MEM_ERR_EN
    .err        (err_obs),
`endif
    .dbg_state  (dbg_state)
  );

`ifndef KV_MEM_ERR_EN
  assign err_obs = 1'b0;
`endif

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  logic          probe    = 1'b0;
  logic          end_req  = 1'b0;
  logic          end_done = 1'b0;
  int            checks   = 0;
  int            failures = 0;

  function automatic logic [EW-1:0] pack(input logic h, input logic [N-1:0] hi,
                                         input logic [VW-1:0] v, input logic fv,
                                         input logic [N-1:0] fi, input logic [CW-1:0] c,
                                         input logic b, input logic e);
    return {h, hi, v, fv, fi, c, b, e};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic sel, input logic wr, input logic del,
                       input logic [N-1:0] idx, input logic [KW-1:0] key,
                       input logic [VW-1:0] val, input logic fl);
    @(negedge clk);
    select_in = sel;
    write_in  = wr;
    delete_in = del;
    idx_in    = idx;
    key_in    = key;
    value_in  = val;
    flush_in  = fl;
    probe     = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic lk(input logic [KW-1:0] key);
    drive(1'b0, 1'b0, 1'b0, '0, key, '0, 1'b0);
  endtask

  task automatic kw(input logic [KW-1:0] key, input logic [VW-1:0] val);
    drive(1'b0, 1'b1, 1'b0, '0, key, val, 1'b0);
  endtask

  task automatic iw(input logic [N-1:0] idx, input logic [KW-1:0] key, input logic [VW-1:0] val);
    drive(1'b1, 1'b1, 1'b0, idx, key, val, 1'b0);
  endtask

  task automatic ir(input logic [N-1:0] idx);
    drive(1'b1, 1'b0, 1'b0, idx, '0, '0, 1'b0);
  endtask

  task automatic dl(input logic [N-1:0] idx);
    drive(1'b0, 1'b0, 1'b1, idx, '0, '0, 1'b0);
  endtask

  task automatic fl(input logic [KW-1:0] key);
    drive(1'b0, 1'b0, 1'b0, '0, key, '0, 1'b1);
  endtask

  // Expectation for the cycle just driven.
  task automatic ex(input string nm, input logic h, input logic [N-1:0] hi,
                    input logic [VW-1:0] v, input logic fv, input logic [N-1:0] fi,
                    input int c, input logic b, input logic e);
    exp_q.push_back(pack(h, hi, v, fv, fi, CW'(c), b, ERR_EN ? e : 1'b0));
    name_q.push_back(nm);
    probe = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e_v;
    logic [EW-1:0] a_v;
    string         nm;
    #2;
    if (probe) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL no_expectation: output cycle with empty expected queue");
      end else begin
        e_v = exp_q.pop_front();
        nm  = name_q.pop_front();
        a_v = pack(hit, hit_idx, value_out, free_valid, free_idx, count, busy, err_obs);
        if (a_v !== e_v) begin
          failures++;
          $display("FAIL %s: got {hit,hit_idx,value,free_valid,free_idx,count,busy,err}=%h expected %h",
                   nm, a_v, e_v);
        end
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL leftover: got %0d unconsumed expectations, expected 0", exp_q.size());
      end
      end_done = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    ex("reset_state", 1'b0, '0, '0, 1'b1, 16'h0001, 0, 1'b0, 1'b0);
    idle();
    rst_n = 1'b1;
    ex("post_reset", 1'b0, '0, '0, 1'b1, 16'h0001, 0, 1'b0, 1'b0);

    // Keyed insert, visible the cycle after.
    kw(32'hA5, 64'h11);
    ex("insert_cycle_miss", 1'b0, '0, '0, 1'b1, 16'h0001, 0, 1'b0, 1'b0);
    lk(32'hA5);
    ex("lookup_a5", 1'b1, 16'h0001, 64'h11, 1'b1, 16'h0002, 1, 1'b0, 1'b0);

    // Keyed overwrite keeps count.
    kw(32'hA5, 64'h22);
    lk(32'hA5);
    ex("overwrite_a5", 1'b1, 16'h0001, 64'h22, 1'b1, 16'h0002, 1, 1'b0, 1'b0);

    // Delete, then delete again (no-op, no error).
    dl(16'h0001);
    lk(32'hA5);
    ex("delete_a5", 1'b0, '0, '0, 1'b1, 16'h0001, 0, 1'b0, 1'b0);
    dl(16'h0001);
    lk(32'hA5);
    ex("delete_empty", 1'b0, '0, '0, 1'b1, 16'h0001, 0, 1'b0, 1'b0);

    // Indexed write and indexed reads.
    iw(16'h0004, 32'h77, 64'h33);
    ir(16'h0004);
    ex("idx_read_hit", 1'b1, 16'h0004, 64'h33, 1'b1, 16'h0001, 1, 1'b0, 1'b0);
    ir(16'h0002);
    ex("idx_read_empty", 1'b0, '0, '0, 1'b1, 16'h0001, 1, 1'b0, 1'b0);

    // Fill remaining 15 cells: order 0,1,3,4,...,15, so key 0x105 -> cell 6.
    for (int i = 0; i < 15; i++) begin
      kw(32'h100 + KW'(i), 64'h1000 + VW'(i));
    end
    lk(32'h105);
    ex("full_lookup", 1'b1, 16'h0040, 64'h1005, 1'b0, '0, 16, 1'b0, 1'b0);

    // Keyed write of a new key on a full array is dropped.
    kw(32'hBEEF, 64'h99);
    lk(32'hBEEF);
    ex("full_drop", 1'b0, '0, '0, 1'b0, '0, 16, 1'b0, 1'b1);
    lk(32'h100);
    ex("full_intact", 1'b1, 16'h0001, 64'h1000, 1'b0, '0, 16, 1'b0, 1'b1);

    // Flush of a full array; a keyed write mid-sweep is ignored.
    fl(32'h100);
    ex("flush_pulse", 1'b1, 16'h0001, 64'h1000, 1'b0, '0, 16, 1'b0, 1'b1);
    for (int j = 1; j <= 16; j++) begin
      if (j == 3) begin
        kw(32'h123, 64'h5);
      end else begin
        lk(32'h10E);
      end
      ex($sformatf("sweep_%0d", j), 1'b0, '0, '0, (j >= 2), (j >= 2) ? 16'h0001 : 16'h0000,
         (j == 1) ? 16 : 17 - j, 1'b1, 1'b0);
    end
    lk(32'h10E);
    ex("flush_done", 1'b0, '0, '0, 1'b1, 16'h0001, 0, 1'b0, 1'b0);
    lk(32'h123);
    ex("flush_write_ignored", 1'b0, '0, '0, 1'b1, 16'h0001, 0, 1'b0, 1'b0);

    // Load 5 cells.
    for (int i = 0; i < 5; i++) begin
      kw(32'h200 + KW'(i), 64'h2000 + VW'(i));
    end
    lk(32'h202);
    ex("load5", 1'b1, 16'h0004, 64'h2002, 1'b1, 16'h0020, 5, 1'b0, 1'b0);

    // Write and delete together on cell 1: delete wins, write dropped.
    drive(1'b1, 1'b1, 1'b1, 16'h0002, 32'h999, 64'h5, 1'b0);
    ir(16'h0002);
    ex("wr_del_same", 1'b0, '0, '0, 1'b1, 16'h0002, 4, 1'b0, 1'b1);
    lk(32'h999);
    ex("wr_del_no_write", 1'b0, '0, '0, 1'b1, 16'h0002, 4, 1'b0, 1'b1);

    // Flush to clear state and the error flag.
    fl('0);
    for (int j = 0; j < 16; j++) begin
      idle();
    end
    lk(32'h200);
    ex("flush2_done", 1'b0, '0, '0, 1'b1, 16'h0001, 0, 1'b0, 1'b0);

    // Delete with non-one-hot index is dropped.
    for (int i = 0; i < 5; i++) begin
      kw(32'h300 + KW'(i), 64'h3000 + VW'(i));
    end
    dl(16'h0003);
    lk(32'h300);
    ex("bad_idx_del_c0", 1'b1, 16'h0001, 64'h3000, 1'b1, 16'h0020, 5, 1'b0, 1'b1);
    lk(32'h301);
    ex("bad_idx_del_c1", 1'b1, 16'h0002, 64'h3001, 1'b1, 16'h0020, 5, 1'b0, 1'b1);

    // Flush, then reset during busy cycle 3.
    fl(32'h300);
    lk(32'h300);
    ex("flush3_c1", 1'b0, '0, '0, 1'b1, 16'h0020, 5, 1'b1, 1'b0);
    lk(32'h301);
    ex("flush3_c2", 1'b0, '0, '0, 1'b1, 16'h0001, 4, 1'b1, 1'b0);
    lk(32'h301);
    rst_n = 1'b0;
    ex("reset_mid_flush", 1'b0, '0, '0, 1'b1, 16'h0001, 0, 1'b0, 1'b0);
    idle();
    idle();
    rst_n = 1'b1;
    lk(32'h303);
    ex("after_reset", 1'b0, '0, '0, 1'b1, 16'h0001, 0, 1'b0, 1'b0);
    idle();
    lk(32'h304);
    ex("sweep_abandoned", 1'b0, '0, '0, 1'b1, 16'h0001, 0, 1'b0, 1'b0);

    // Wrap up.
    idle();
    end_req = 1'b1;
    for (int t = 0; t < 20 && !end_done; t++) begin
      @(negedge clk);
      #3;
    end
    if (!end_done) begin
      $display("FAIL monitor_timeout: got no end-of-run acknowledge, expected one within 20 cycles");
      $fatal(1, "monitor did not finish");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
